// File: rtl/iram_arb.sv
// rtl/iram_arb.sv - instruction RAM arbiter between fetch stage and loader/debug port
//
// Purpose:
//   Shares one synchronous single-port IRAM (1-cycle read latency) between the
//   fetch stage and a loader/debug port. One grant per cycle at most, read data
//   is steered back to whichever requester owned the read one cycle earlier.
//
// Optional feature macro: IRAM_ARB_STARVE_EN
//   Defined   : loader is forced to win after STARVE_LIMIT consecutive losses.
//   Undefined : fetch has strict priority except while LdLock is high.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   FetchReq/FetchAddr    fetch read request
//   FetchGnt              fetch accepted this cycle (combinational)
//   FetchData/FetchValid  fetch read return (valid one cycle after grant)
//   Stall                 hold fetch stage (combinational)
//   LdReq/LdWe/LdAddr     loader request, write strobe, address
//   LdWData/LdLock        loader write data, exclusive-ownership lock
//   LdGnt                 loader accepted this cycle (combinational)
//   LdRData/LdValid       loader read return (reads only)
//   MemEn/MemWe/MemAddr   IRAM command
//   MemWData/MemRData     IRAM write data / read data

module iram_arb #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] FetchAddr,
    output logic              FetchGnt,
    output logic [31:0]       FetchData,
    output logic              FetchValid,
    output logic              Stall,

    input  logic              LdReq,
    input  logic              LdWe,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [31:0]       LdWData,
    input  logic              LdLock,
    output logic              LdGnt,
    output logic [31:0]       LdRData,
    output logic              LdValid,

    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    input  logic [31:0]       MemRData
);

    typedef enum logic [1:0] {
        ST_NONE  = 2'd0,
        ST_RET_F = 2'd1,
        ST_RET_L = 2'd2
    } ret_state_t;

    ret_state_t  r_state;
    ret_state_t  w_state_next;

    logic        w_starve_force;
    logic        w_fetch_gnt;
    logic        w_ld_gnt;
    logic        w_fetch_valid;
    logic        w_ld_valid;
    logic [31:0] r_fetch_hold;
    logic [31:0] r_ld_hold;

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles the loader asked and
    // lost. It can never pass STARVE_LIMIT because reaching the limit
    // forces a loader grant, which clears it.
    // ------------------------------------------------------------------
`ifdef IRAM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_starve_cnt <= '0;
        end else if (LdReq && !w_ld_gnt) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Only meaningful while the loader is still asking.
    assign w_starve_force = LdReq && (r_starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign w_starve_force = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Grant priority: locked loader, starved loader, fetch, idle loader.
    // A lock blocks fetch even when the loader has nothing to do.
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_gnt = 1'b0;
        w_ld_gnt    = 1'b0;
        if (!Reset) begin
            if (LdLock) begin
                w_ld_gnt = LdReq;
            end else if (w_starve_force) begin
                w_ld_gnt = 1'b1;
            end else if (FetchReq) begin
                w_fetch_gnt = 1'b1;
            end else if (LdReq) begin
                w_ld_gnt = 1'b1;
            end
        end
    end

    assign FetchGnt = w_fetch_gnt;
    assign LdGnt    = w_ld_gnt;
    assign Stall    = Reset || (FetchReq && !w_fetch_gnt);

    // IRAM command is driven by the winner in the grant cycle.
    assign MemEn    = w_fetch_gnt || w_ld_gnt;
    assign MemWe    = w_ld_gnt && LdWe;
    assign MemAddr  = w_ld_gnt ? LdAddr : FetchAddr;
    assign MemWData = LdWData;

    // ------------------------------------------------------------------
    // Pending-return FSM: remembers who owns the read data arriving next
    // cycle. Loader writes return nothing.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_NONE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_NONE;
        if (w_fetch_gnt) begin
            w_state_next = ST_RET_F;
        end else if (w_ld_gnt && !LdWe) begin
            w_state_next = ST_RET_L;
        end
    end

    // A return already in flight when Reset rises is dropped, so valids are
    // masked by Reset as well as by the state.
    always_comb begin
        w_fetch_valid = 1'b0;
        w_ld_valid    = 1'b0;
        case (r_state)
            ST_RET_F: w_fetch_valid = !Reset;
            ST_RET_L: w_ld_valid    = !Reset;
            default: begin
                w_fetch_valid = 1'b0;
                w_ld_valid    = 1'b0;
            end
        endcase
    end

    assign FetchValid = w_fetch_valid;
    assign LdValid    = w_ld_valid;

    // ------------------------------------------------------------------
    // Return data passes straight through from the IRAM in the valid
    // cycle and is captured so the outputs keep the last value after.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fetch_hold <= '0;
            r_ld_hold    <= '0;
        end else begin
            if (w_fetch_valid) begin
                r_fetch_hold <= MemRData;
            end
            if (w_ld_valid) begin
                r_ld_hold <= MemRData;
            end
        end
    end

    assign FetchData = w_fetch_valid ? MemRData : r_fetch_hold;
    assign LdRData   = w_ld_valid    ? MemRData : r_ld_hold;

endmodule

// File: tb/tb_iram_arb.sv
// tb/tb_iram_arb.sv - self-checking bench for iram_arb

module tb_iram_arb;

    localparam int ADDR_W       = 8;
    localparam int STARVE_LIMIT = 4;
`ifdef IRAM_ARB_STARVE_EN
    localparam int EXP_LD_WINS = 2;
`else
    localparam int EXP_LD_WINS = 0;
`endif

    logic              Clk;
    logic              Reset;
    logic              FetchReq;
    logic [ADDR_W-1:0] FetchAddr;
    logic              FetchGnt;
    logic [31:0]       FetchData;
    logic              FetchValid;
    logic              Stall;
    logic              LdReq;
    logic              LdWe;
    logic [ADDR_W-1:0] LdAddr;
    logic [31:0]       LdWData;
    logic              LdLock;
    logic              LdGnt;
    logic [31:0]       LdRData;
    logic              LdValid;
    logic              MemEn;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWData;
    logic [31:0]       MemRData;

    int n_chk = 0;
    int n_err = 0;

    iram_arb #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .Clk(Clk), .Reset(Reset),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchGnt(FetchGnt),
        .FetchData(FetchData), .FetchValid(FetchValid), .Stall(Stall),
        .LdReq(LdReq), .LdWe(LdWe), .LdAddr(LdAddr), .LdWData(LdWData),
        .LdLock(LdLock), .LdGnt(LdGnt), .LdRData(LdRData), .LdValid(LdValid),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous IRAM attached to the DUT.
    logic [31:0] iram [256];
    always @(posedge Clk) begin
        if (MemEn) begin
            if (MemWe) iram[MemAddr] <= MemWData;
            else       MemRData      <= iram[MemAddr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who should win from the priority list, a shadow
    // memory updated in grant order, and a one-deep return per requester.
    // ------------------------------------------------------------------
    logic [31:0] m_mem [256];
    int          m_cnt;
    logic        m_fv, m_lv;
    logic [31:0] m_fd_pend, m_ld_pend, m_fd_hold, m_ld_hold;
    logic        m_started;
    logic        e_gf, e_gl, e_force;

    always_comb begin
        e_gf = 1'b0;
        e_gl = 1'b0;
`ifdef IRAM_ARB_STARVE_EN
        e_force = LdReq && (m_cnt == STARVE_LIMIT);
`else
        e_force = 1'b0;
`endif
        if (Reset)                 begin e_gf = 1'b0; e_gl = 1'b0; end
        else if (LdLock && LdReq)  e_gl = 1'b1;
        else if (LdLock)           e_gl = 1'b0;
        else if (e_force)          e_gl = 1'b1;
        else if (FetchReq)         e_gf = 1'b1;
        else if (LdReq)            e_gl = 1'b1;
    end

    always @(posedge Clk) begin
        m_started <= 1'b1;
        if (Reset) begin
            m_fv      <= 1'b0;
            m_lv      <= 1'b0;
            m_fd_hold <= '0;
            m_ld_hold <= '0;
            m_cnt     <= 0;
        end else begin
            if (m_fv) m_fd_hold <= m_fd_pend;
            if (m_lv) m_ld_hold <= m_ld_pend;
            m_fv <= e_gf;
            if (e_gf) m_fd_pend <= m_mem[FetchAddr];
            m_lv <= e_gl && !LdWe;
            if (e_gl && !LdWe) m_ld_pend <= m_mem[LdAddr];
            if (e_gl && LdWe)  m_mem[LdAddr] <= LdWData;
            m_cnt <= (LdReq && !e_gl) ? m_cnt + 1 : 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge Clk) begin
        if (m_started) begin
            logic        efv, elv;
            efv = m_fv && !Reset;
            elv = m_lv && !Reset;
            chk("fetch_gnt", 32'(FetchGnt), 32'(e_gf));
            chk("ld_gnt", 32'(LdGnt), 32'(e_gl));
            chk("one_hot_gnt", 32'(FetchGnt && LdGnt), 32'd0);
            chk("mem_en", 32'(MemEn), 32'(e_gf || e_gl));
            chk("mem_we", 32'(MemWe), 32'(e_gl && LdWe));
            chk("stall", 32'(Stall), 32'(Reset || (FetchReq && !e_gf)));
            if (e_gf) chk("mem_addr_f", 32'(MemAddr), 32'(FetchAddr));
            if (e_gl) chk("mem_addr_l", 32'(MemAddr), 32'(LdAddr));
            if (e_gl && LdWe) chk("mem_wdata", MemWData, LdWData);
            chk("fetch_valid", 32'(FetchValid), 32'(efv));
            chk("ld_valid", 32'(LdValid), 32'(elv));
            chk("fetch_data", FetchData, efv ? m_fd_pend : m_fd_hold);
            chk("ld_rdata", LdRData, elv ? m_ld_pend : m_ld_hold);
        end
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        FetchReq = 1'b0; LdReq = 1'b0; LdWe = 1'b0; LdLock = 1'b0;
    endtask

    int ld_wins;
    int f_wins;

    initial begin
        m_started = 1'b0;
        for (int i = 0; i < 256; i++) begin
            iram[i]  = 32'h1000_0000 + 32'(i);
            m_mem[i] = 32'h1000_0000 + 32'(i);
        end
        iram[8'h10]  = 32'h2008_0005;
        m_mem[8'h10] = 32'h2008_0005;
        m_fd_pend = '0; m_ld_pend = '0;
        MemRData  = '0;

        // Reset with both requesters active: nothing may be granted.
        Reset = 1'b1; FetchReq = 1'b1; FetchAddr = 8'h10;
        LdReq = 1'b1; LdWe = 1'b0; LdAddr = 8'h10; LdWData = '0; LdLock = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_fetch_gnt", 32'(FetchGnt), 32'd0);
        chk("rst_ld_gnt", 32'(LdGnt), 32'd0);
        chk("rst_mem_en", 32'(MemEn), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd1);
        chk("rst_fetch_valid", 32'(FetchValid), 32'd0);
        chk("rst_fetch_data", FetchData, 32'd0);
        chk("rst_ld_rdata", LdRData, 32'd0);

        // Basic fetch read.
        next_cycle();
        Reset = 1'b0; LdReq = 1'b0; FetchReq = 1'b1; FetchAddr = 8'h10;
        @(negedge Clk);
        chk("f1_gnt", 32'(FetchGnt), 32'd1);
        chk("f1_stall", 32'(Stall), 32'd0);
        next_cycle();
        FetchReq = 1'b0;
        @(negedge Clk);
        chk("f1_valid", 32'(FetchValid), 32'd1);
        chk("f1_data", FetchData, 32'h2008_0005);

        // Locked loader write wins over fetch.
        next_cycle();
        LdLock = 1'b1; LdReq = 1'b1; LdWe = 1'b1; LdAddr = 8'h40; LdWData = 32'hDEAD_BEEF;
        FetchReq = 1'b1; FetchAddr = 8'h40;
        @(negedge Clk);
        chk("lk_ld_gnt", 32'(LdGnt), 32'd1);
        chk("lk_mem_we", 32'(MemWe), 32'd1);
        chk("lk_stall", 32'(Stall), 32'd1);
        chk("lk_hold_data", FetchData, 32'h2008_0005);
        next_cycle();
        LdReq = 1'b0;
        @(negedge Clk);
        chk("lk_idle_fetch_gnt", 32'(FetchGnt), 32'd0);
        chk("lk_no_wr_valid", 32'(LdValid), 32'd0);
        next_cycle();
        LdLock = 1'b0; LdWe = 1'b0;
        next_cycle();
        FetchReq = 1'b0;
        @(negedge Clk);
        chk("lk_readback", FetchData, 32'hDEAD_BEEF);

        // Both requesting for 10 cycles.
        next_cycle();
        FetchReq = 1'b1; FetchAddr = 8'h30; LdReq = 1'b1; LdWe = 1'b0; LdAddr = 8'h20;
        ld_wins = 0; f_wins = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (LdGnt) ld_wins++;
            if (FetchGnt) f_wins++;
            next_cycle();
        end
        chk("starve_ld_wins", 32'(ld_wins), 32'(EXP_LD_WINS));
        chk("starve_f_wins", 32'(f_wins), 32'(10 - EXP_LD_WINS));
        idle();
        next_cycle();

        // Alternating fetch/loader reads.
        FetchReq = 1'b1; FetchAddr = 8'h11;
        @(negedge Clk);
        chk("alt_f_gnt", 32'(FetchGnt), 32'd1);
        next_cycle();
        FetchReq = 1'b0; LdReq = 1'b1; LdAddr = 8'h22;
        @(negedge Clk);
        chk("alt_l_gnt", 32'(LdGnt), 32'd1);
        chk("alt_f_valid", 32'(FetchValid), 32'd1);
        chk("alt_f_data", FetchData, 32'h1000_0011);
        next_cycle();
        LdReq = 1'b0; FetchReq = 1'b1; FetchAddr = 8'h13;
        @(negedge Clk);
        chk("alt_l_valid", 32'(LdValid), 32'd1);
        chk("alt_l_data", LdRData, 32'h1000_0022);
        chk("alt_f_not_valid", 32'(FetchValid), 32'd0);
        next_cycle();
        FetchReq = 1'b0; LdReq = 1'b1; LdAddr = 8'h24;
        @(negedge Clk);
        chk("alt_f2_data", FetchData, 32'h1000_0013);
        next_cycle();
        idle();
        @(negedge Clk);
        chk("alt_l2_data", LdRData, 32'h1000_0024);

        // Same-address fetch read and loader write: grant order, no forwarding.
        next_cycle();
        FetchReq = 1'b1; FetchAddr = 8'h50;
        LdReq = 1'b1; LdWe = 1'b1; LdAddr = 8'h50; LdWData = 32'h55AA_55AA;
        @(negedge Clk);
        chk("sa_fetch_first", 32'(FetchGnt), 32'd1);
        next_cycle();
        FetchReq = 1'b0;
        @(negedge Clk);
        chk("sa_ld_second", 32'(LdGnt), 32'd1);
        chk("sa_old_data", FetchData, 32'h1000_0050);
        next_cycle();
        LdReq = 1'b0; LdWe = 1'b0; FetchReq = 1'b1;
        next_cycle();
        FetchReq = 1'b0;
        @(negedge Clk);
        chk("sa_new_data", FetchData, 32'h55AA_55AA);

        // Reset right after a fetch grant drops the return.
        next_cycle();
        FetchReq = 1'b1; FetchAddr = 8'h12;
        next_cycle();
        Reset = 1'b1; LdReq = 1'b1;
        @(negedge Clk);
        chk("rr_valid", 32'(FetchValid), 32'd0);
        chk("rr_gnt", 32'(FetchGnt || LdGnt), 32'd0);
        chk("rr_stall", 32'(Stall), 32'd1);
        next_cycle();
        @(negedge Clk);
        chk("rr_valid2", 32'(FetchValid), 32'd0);
        next_cycle();
        Reset = 1'b0; idle();
        @(negedge Clk);
        chk("rr_valid3", 32'(FetchValid), 32'd0);
        chk("rr_data_cleared", FetchData, 32'd0);

        repeat (3) next_cycle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/iram_arb.md
IRAM_ARB -- requirements
Module: iram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning IRAM address width in bits.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive lost loader requests before the loader is forced to win.
REQ-003 Clk  input  1  clock; all state SHALL update on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-005 FetchReq  input  1  fetch stage requests an instruction read.
REQ-006 FetchAddr  input  ADDR_W  fetch read address.
REQ-007 FetchGnt  output  1  fetch request accepted this cycle (combinational).
REQ-008 FetchData  output  32  read data returned to fetch.
REQ-009 FetchValid  output  1  FetchData valid (registered).
REQ-010 Stall  output  1  hold fetch stage (combinational).
REQ-011 LdReq  input  1  loader/debug port requests an access.
REQ-012 LdWe  input  1  loader access is a write (1) or a read (0).
REQ-013 LdAddr  input  ADDR_W  loader address.
REQ-014 LdWData  input  32  loader write data.
REQ-015 LdLock  input  1  loader holds IRAM exclusively (program download).
REQ-016 LdGnt  output  1  loader request accepted this cycle (combinational).
REQ-017 LdRData  output  32  loader read data.
REQ-018 LdValid  output  1  LdRData valid (registered).
REQ-019 MemEn, MemWe  output  1 each  IRAM enable and write strobe.
REQ-020 MemAddr  output  ADDR_W; MemWData  output  32; MemRData  input  32 (synchronous IRAM, 1-cycle read latency).

Function
REQ-021 At most one of FetchGnt and LdGnt SHALL be high in any cycle.
REQ-022 Priority SHALL be: LdLock&LdReq -> loader; else starve-force -> loader; else FetchReq -> fetch; else LdReq -> loader; else idle.
REQ-023 While LdLock is high, FetchGnt SHALL be 0 even when LdReq is low.
REQ-024 Granted requester's address, data and write strobe SHALL drive MemAddr/MemWData/MemWe in the grant cycle; MemEn = FetchGnt|LdGnt.
REQ-025 The pending-return FSM SHALL have states NONE, RET_F and RET_L; next state = RET_F on FetchGnt, RET_L on LdGnt&~LdWe, else NONE.
REQ-026 In RET_F, FetchValid=1 and FetchData=MemRData; in RET_L, LdValid=1 and LdRData=MemRData; read latency = 1 cycle after grant; back-to-back grants SHALL be pipelined with no bubble.
REQ-027 Loader writes SHALL produce no LdValid.
REQ-028 Stall SHALL be Reset | (FetchReq & ~FetchGnt).
REQ-029 Same-cycle loader write and fetch read of one address: the loser's access occurs in a later cycle and sees memory in grant order; no forwarding.
REQ-030 FetchData/LdRData SHALL hold the last value when the respective Valid is 0.

Reset
REQ-031 On Reset, the FSM SHALL go to NONE, the starve counter to 0, and FetchValid, LdValid, FetchData and LdRData to 0.
REQ-032 During Reset, FetchGnt, LdGnt, MemEn and MemWe SHALL be 0 and Stall SHALL be 1.
REQ-033 A read granted in the cycle Reset asserts SHALL have its return dropped (no Valid in the following cycle).

Configuration
REQ-034 With macro IRAM_ARB_STARVE_EN defined, a counter SHALL increment each cycle that LdReq is high and LdGnt is low, and clear on LdGnt or ~LdReq.
REQ-035 Starve-force SHALL be active when the counter equals STARVE_LIMIT.
REQ-036 With IRAM_ARB_STARVE_EN undefined, there SHALL be no counter, starve-force SHALL be 0, and fetch SHALL have strict priority except under LdLock.

Verification
REQ-037 Reset 3 cycles, then FetchReq=1, FetchAddr=0x10, mem[0x10]=0x20080005 -> FetchGnt=1 the same cycle; FetchValid=1 with FetchData=0x20080005 the next cycle; Stall=0.
REQ-038 LdLock=1, LdReq=1, LdWe=1, LdAddr=0x40, LdWData=0xDEADBEEF with FetchReq=1 -> LdGnt=1, MemWe=1, Stall=1; a later fetch of 0x40 returns 0xDEADBEEF.
REQ-039 FetchReq and LdReq held high, STARVE_EN defined, STARVE_LIMIT=4 -> fetch wins 4 cycles, loader wins cycle 5, pattern repeats; without the macro, the loader never wins.
REQ-040 Alternating fetch-read and loader-read grants on consecutive cycles -> FetchValid and LdValid alternate one cycle later, never both high.
REQ-041 Assert Reset in the cycle after a fetch grant -> FetchValid=0 in the cycles after Reset asserts, Stall=1, and all grants are 0.
